// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry pipeline stage (main + skid) with a valid/ready
// handshake on both sides, synchronous flush and a saturating stall counter.
// Build option: define PIPE_FLUSH_KEEP_PC_EN so that a flush loads in_pc into out_pc
// (the bubble carries a PC). Without the macro, a flush clears out_pc to 0.
module pipe_skid_reg #(
   parameter int unsigned DATA_W = 160,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_pc,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_pc,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t              state;
   logic [31:0]         skid_pc;
   logic [DATA_W-1:0]   skid_data;
   logic                ih;
   logic                oh;

   // The stage accepts input unless both entries are occupied.
   assign in_ready = (state != TWO);
   assign ih       = in_valid & in_ready;
   assign oh       = out_valid & out_ready;

   // Entry FSM: main entry drives the outputs, skid absorbs one extra beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         out_pc    <= 32'd0;
         out_data  <= '0;
         skid_pc   <= 32'd0;
         skid_data <= '0;
      end else if (flush) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         out_data  <= '0;
`ifdef PIPE_FLUSH_KEEP_PC_EN
         out_pc    <= in_pc;
`else
         out_pc    <= 32'd0;
`endif
      end else begin
         unique case (state)
            EMPTY: begin
               if (ih) begin
                  state     <= ONE;
                  out_valid <= 1'b1;
                  out_pc    <= in_pc;
                  out_data  <= in_data;
               end
            end
            ONE: begin
               if (ih && oh) begin
                  out_pc    <= in_pc;
                  out_data  <= in_data;
               end else if (ih) begin
                  state     <= TWO;
                  skid_pc   <= in_pc;
                  skid_data <= in_data;
               end else if (oh) begin
                  // Outputs keep their last values while empty.
                  state     <= EMPTY;
                  out_valid <= 1'b0;
               end
            end
            TWO: begin
               if (oh) begin
                  state     <= ONE;
                  out_pc    <= skid_pc;
                  out_data  <= skid_data;
               end
            end
            default: begin
               state     <= EMPTY;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   // Saturating count of cycles where a valid output is back-pressured.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus random
// traffic, compared against a queue-based reference model.
// Honours PIPE_FLUSH_KEEP_PC_EN the same way as the design.
module tb_pipe_skid_reg;

   localparam int unsigned DATA_W = 160;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0]       in_pc, out_pc;
   logic [DATA_W-1:0] in_data, out_data;
   logic [CNT_W-1:0]  stall_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model: FIFO of at most two entries plus last shown values.
   logic [31:0]       mq_pc[$];
   logic [DATA_W-1:0] mq_data[$];
   logic [31:0]       m_pc;
   logic [DATA_W-1:0] m_data;
   int unsigned       m_cnt;

   pipe_skid_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_data(out_data), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] rand_data();
      logic [DATA_W-1:0] d;
      for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                      input logic [DATA_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one edge using the inputs currently driven.
   task automatic model_edge();
      bit push_ok, pop_ok;
      if (rst) begin
         mq_pc.delete(); mq_data.delete();
         m_pc = 32'd0; m_data = '0; m_cnt = 0;
      end else begin
         if (mq_pc.size() > 0 && !out_ready && m_cnt < CNT_MAX) m_cnt++;
         if (flush) begin
            mq_pc.delete(); mq_data.delete();
            m_data = '0;
`ifdef PIPE_FLUSH_KEEP_PC_EN
            m_pc = in_pc;
`else
            m_pc = 32'd0;
`endif
         end else begin
            push_ok = in_valid && (mq_pc.size() < 2);
            pop_ok  = (mq_pc.size() > 0) && out_ready;
            if (pop_ok) begin
               void'(mq_pc.pop_front());
               void'(mq_data.pop_front());
            end
            if (push_ok) begin
               mq_pc.push_back(in_pc);
               mq_data.push_back(in_data);
            end
            if (mq_pc.size() > 0) begin
               m_pc   = mq_pc[0];
               m_data = mq_data[0];
            end
         end
      end
   endtask

   task automatic check_all();
      chk("out_valid", DATA_W'(out_valid), DATA_W'(mq_pc.size() > 0));
      chk("in_ready",  DATA_W'(in_ready),  DATA_W'(mq_pc.size() < 2));
      chk("out_pc",    DATA_W'(out_pc),    DATA_W'(m_pc));
      chk("out_data",  out_data,           m_data);
      chk("stall_cnt", DATA_W'(stall_cnt), DATA_W'(m_cnt));
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic ordy);
      in_valid  = v;
      in_pc     = pc;
      in_data   = rand_data();
      out_ready = ordy;
   endtask

   task automatic do_reset();
      rst = 1'b1; flush = 1'b1;
      step();
      rst = 1'b0; flush = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0;
      drive(1'b0, 32'd0, 1'b0);
      m_pc = '0; m_data = '0; m_cnt = 0;

      // Reset state
      do_reset();
      chk("rst_in_ready", DATA_W'(in_ready), DATA_W'(1));
      chk("rst_out_pc", DATA_W'(out_pc), DATA_W'(0));

      // Pass-through with one-cycle latency
      drive(1'b1, 32'h3000, 1'b1); step();
      chk("pt_pc0", DATA_W'(out_pc), DATA_W'(32'h3000));
      drive(1'b1, 32'h3004, 1'b1); step();
      chk("pt_pc1", DATA_W'(out_pc), DATA_W'(32'h3004));
      drive(1'b1, 32'h3008, 1'b1); step();
      chk("pt_pc2", DATA_W'(out_pc), DATA_W'(32'h3008));
      chk("pt_ready", DATA_W'(in_ready), DATA_W'(1));
      drive(1'b0, 32'h0, 1'b1); step();
      chk("pt_drain", DATA_W'(out_valid), DATA_W'(0));
      chk("pt_keep_pc", DATA_W'(out_pc), DATA_W'(32'h3008));

      // Skid fill and in-order drain
      drive(1'b1, 32'h3000, 1'b0); step();
      drive(1'b1, 32'h3004, 1'b0); step();
      chk("skid_full", DATA_W'(in_ready), DATA_W'(0));
      drive(1'b1, 32'h3008, 1'b0); step(); step();
      chk("skid_hold", DATA_W'(out_pc), DATA_W'(32'h3000));
      out_ready = 1'b1; step();
      chk("skid_out1", DATA_W'(out_pc), DATA_W'(32'h3004));
      step();
      chk("skid_out2", DATA_W'(out_pc), DATA_W'(32'h3008));
      in_valid = 1'b0; step();
      chk("skid_empty", DATA_W'(out_valid), DATA_W'(0));

      // Flush in TWO with concurrent input
      drive(1'b1, 32'h5000, 1'b0); step();
      drive(1'b1, 32'h5004, 1'b0); step();
      drive(1'b1, 32'h4180, 1'b0); flush = 1'b1; step(); flush = 1'b0;
      chk("fl_valid", DATA_W'(out_valid), DATA_W'(0));
      chk("fl_data", out_data, '0);
`ifdef PIPE_FLUSH_KEEP_PC_EN
      chk("fl_pc", DATA_W'(out_pc), DATA_W'(32'h4180));
`else
      chk("fl_pc", DATA_W'(out_pc), DATA_W'(0));
`endif
      chk("fl_ready", DATA_W'(in_ready), DATA_W'(1));

      // Stall counter saturation
      do_reset();
      drive(1'b1, 32'h6000, 1'b0); step();
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) step();
      chk("stall_sat", DATA_W'(stall_cnt), DATA_W'(15));

      // Reset with flush in TWO
      drive(1'b1, 32'h7004, 1'b0); step();
      chk("pre_rst_full", DATA_W'(in_ready), DATA_W'(0));
      do_reset();
      chk("rst2_cnt", DATA_W'(stall_cnt), DATA_W'(0));
      chk("rst2_data", out_data, '0);
      chk("rst2_ready", DATA_W'(in_ready), DATA_W'(1));

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0));
         flush = ($urandom_range(0, 29) == 0);
         rst   = ($urandom_range(0, 99) == 0);
         step();
      end
      rst = 1'b0; flush = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
